// File: rtl/cla_seq_ctrl_if.sv
// Handshake and operand/result bundle between the board input logic and the add sequencer.
interface cla_seq_ctrl_if #(parameter int WIDTH = 16) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;
  logic             slice_g;
  logic             slice_p;

  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, c_out, overflow, slice_g, slice_p
  );

  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, c_out, overflow, slice_g, slice_p
  );
endinterface

// File: rtl/cla_seq_ctrl.sv
// Multi-cycle adder: SLICE bits per RUN cycle through a carry-lookahead slice,
// with the carry registered between slices and a start/busy/done handshake.
module cla_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input logic          clk,
    input logic          rst,
    cla_seq_ctrl_if.slave bus
);
    localparam int N    = WIDTH / SLICE;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t            state;
    logic [IDXW-1:0]   idx;
    logic              carry;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [WIDTH-1:0]  sum_r;
    logic              busy_r;
    logic              done_r;
    logic              c_out_r;
    logic              ovf_r;

    logic [SLICE-1:0]  sa, sb, g, p, s;
    logic [SLICE:0]    c;
    logic              grp_g;
    logic              grp_p;

    // One lookahead slice; the group generate is the slice carry-out assuming c[0]=0.
    always_comb begin
        sa    = op_a[int'(idx)*SLICE +: SLICE];
        sb    = op_b[int'(idx)*SLICE +: SLICE];
        g     = sa & sb;
        p     = sa | sb;
        c     = '0;
        c[0]  = carry;
        grp_g = 1'b0;
        for (int unsigned i = 0; i < SLICE; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
            grp_g  = g[i] | (p[i] & grp_g);
        end
        grp_p = &p;
        s     = (p & ~g) ^ c[SLICE-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            carry   <= 1'b0;
            op_a    <= '0;
            op_b    <= '0;
            sum_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            c_out_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_a    <= bus.a;
                        op_b    <= bus.b;
                        carry   <= bus.c_in;
                        sum_r   <= '0;
                        c_out_r <= 1'b0;
                        ovf_r   <= 1'b0;
                        idx     <= '0;
                        busy_r  <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: state <= RUN;
                RUN: begin
                    sum_r[int'(idx)*SLICE +: SLICE] <= s;
                    carry <= c[SLICE];
                    if (idx == IDXW'(N - 1)) begin
                        c_out_r <= c[SLICE];
                        ovf_r   <= c[SLICE-1] ^ c[SLICE];
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state   <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.sum      = sum_r;
    assign bus.c_out    = c_out_r;
    assign bus.overflow = ovf_r;
    assign bus.slice_g  = (state == RUN) & grp_g;
    assign bus.slice_p  = (state == RUN) & grp_p;
endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Directed and random adds against an arithmetic reference of a+b+c_in.
module tb_cla_seq_ctrl;
    localparam int WIDTH = 16;
    localparam int SLICE = 4;
    localparam int N     = WIDTH / SLICE;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    cla_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    cla_seq_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One add. pulse_mask bit k re-asserts start after cycle k; b2b means start is
    // still high from a previous add so the sampling edge is one IDLE cycle later.
    task automatic do_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input bit hold, input bit b2b,
                          input int unsigned pulse_mask, input string tag);
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_cout, exp_ovf;
        logic [SLICE-1:0] as, bs;
        logic [SLICE:0]   gsum;
        full     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        exp_sum  = full[WIDTH-1:0];
        exp_cout = full[WIDTH];
        exp_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (exp_sum[WIDTH-1] != a[WIDTH-1]);

        @(negedge clk);
        bus.a = a; bus.b = b; bus.c_in = cin; bus.start = 1'b1;
        if (b2b) begin
            @(posedge clk); #1;
            chk({tag, "_b2b_idle_busy"}, 32'(bus.busy), 32'd0);
            chk({tag, "_b2b_idle_done"}, 32'(bus.done), 32'd0);
        end
        @(posedge clk); #1;
        bus.start = hold;
        chk({tag, "_load_busy"}, 32'(bus.busy), 32'd1);
        chk({tag, "_load_sum"},  32'(bus.sum),  32'd0);
        chk({tag, "_load_sg"},   32'(bus.slice_g), 32'd0);
        for (int k = 1; k <= N + 1; k++) begin
            @(posedge clk); #1;
            bus.start = pulse_mask[k] ? 1'b1 : hold;
            bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom); bus.c_in = 1'($urandom);
            if (k <= N) begin
                as   = a[(k-1)*SLICE +: SLICE];
                bs   = b[(k-1)*SLICE +: SLICE];
                gsum = {1'b0, as} + {1'b0, bs};
                chk({tag, "_run_busy"}, 32'(bus.busy), 32'd1);
                chk({tag, "_run_done"}, 32'(bus.done), 32'd0);
                chk({tag, "_slice_g"},  32'(bus.slice_g), 32'(gsum[SLICE]));
                chk({tag, "_slice_p"},  32'(bus.slice_p), 32'(&(as | bs)));
            end else begin
                chk({tag, "_done"},  32'(bus.done),     32'd1);
                chk({tag, "_busy"},  32'(bus.busy),     32'd0);
                chk({tag, "_sum"},   32'(bus.sum),      32'(exp_sum));
                chk({tag, "_cout"},  32'(bus.c_out),    32'(exp_cout));
                chk({tag, "_ovf"},   32'(bus.overflow), 32'(exp_ovf));
            end
        end
        if (!hold) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
            chk({tag, "_idle_busy"},  32'(bus.busy), 32'd0);
            @(posedge clk); #1;
            chk({tag, "_hold_sum"},   32'(bus.sum),  32'(exp_sum));
            chk({tag, "_hold_cout"},  32'(bus.c_out), 32'(exp_cout));
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.c_in = 1'b0;
        #12;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sum",  32'(bus.sum),  32'd0);
        chk("rst_cout", 32'(bus.c_out), 32'd0);
        chk("rst_ovf",  32'(bus.overflow), 32'd0);
        @(negedge clk); rst = 1'b0;

        do_add(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 0, "t1");
        do_add(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 0, "t2");
        do_add(16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b0, 0, "t3");
        do_add(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 0, "t3b");
        // start pulses during RUN and during DONE must be ignored
        do_add(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0, (1 << 2) | (1 << 5), "t4");
        repeat (N + 3) begin
            @(posedge clk); #1;
            chk("t4_no_extra_done", 32'(bus.done), 32'd0);
            chk("t4_no_restart",    32'(bus.busy), 32'd0);
        end
        chk("t4_sum_kept", 32'(bus.sum), 32'h5556);

        // Abort in RUN at idx=2
        @(negedge clk);
        bus.a = 16'hAAAA; bus.b = 16'h5555; bus.c_in = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_busy", 32'(bus.busy), 32'd0);
        chk("t5_sum",  32'(bus.sum),  32'd0);
        chk("t5_done", 32'(bus.done), 32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (N + 3) begin
            @(posedge clk); #1;
            chk("t5_no_done", 32'(bus.done), 32'd0);
        end
        do_add(16'hAAAA, 16'h5555, 1'b1, 1'b0, 1'b0, 0, "t5_new");

        // Back-to-back with start held high
        do_add(16'h0F0F, 16'hF0F1, 1'b0, 1'b1, 1'b0, 0, "t6a");
        do_add(16'h0F0F, 16'hF0F1, 1'b0, 1'b1, 1'b1, 0, "t6b");
        do_add(16'h7777, 16'h1111, 1'b1, 1'b0, 1'b1, 0, "t6c");

        for (int i = 0; i < 24; i++) begin
            logic [WIDTH-1:0] ra, rb;
            logic             rc;
            ra = WIDTH'($urandom); rb = WIDTH'($urandom); rc = 1'($urandom);
            if (i % 6 == 0) rb = ~ra;
            do_add(ra, rb, rc, 1'b0, 1'b0, 0, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
